instr_encoder_loader: RTL and testbench

- Inverse of the control-unit decode path: accepts decoded instruction fields over a valid/ready stream and packs each into a 32-bit MIPS word.
- Writes the packed words sequentially into instruction memory.
- Used by the testbench/boot path to load programs (R-type, LW, SW, BEQ, ADDI) into imem before the datapath runs.
- Field layouts match what the control unit decodes: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].

---
 rtl/instr_encoder_loader_pkg.sv | 19 +
 rtl/instr_encoder_loader_pack.sv | 29 ++
 rtl/instr_encoder_loader.sv | 100 ++++++++++
 tb/tb_instr_encoder_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode, instruction-class and loader FSM definitions.
// The control unit decodes against the same opcode constants.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_LW   = 3'd1;
  localparam logic [2:0] CLS_SW   = 3'd2;
  localparam logic [2:0] CLS_BEQ  = 3'd3;
  localparam logic [2:0] CLS_ADDI = 3'd4;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational packer: instruction class plus decoded fields -> 32-bit MIPS word.
// Classes 5-7 raise illegal and yield a zero word.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_R:    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      CLS_LW:   word = {OP_LW,    rs, rt, imm};
      CLS_SW:   word = {OP_SW,    rs, rt, imm};
      CLS_BEQ:  word = {OP_BEQ,   rs, rt, imm};
      CLS_ADDI: word = {OP_ADDI,  rs, rt, imm};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts decoded field bundles and writes packed MIPS words
// into consecutive imem addresses starting at BASE_ADDR.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              illegal;
  logic              xfer;

  instr_pack u_pack (
    .cls     (in_class),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // Full is detected on the write to the last address, so the pointer never wraps in-session.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (xfer && (in_last || (!illegal && ptr == LAST))) state_nx = DONE;
      DONE:    if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= BASE;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (state != LOAD && start) begin
        ptr   <= BASE;
        count <= '0;
        err   <= 1'b0;
      end
      if (xfer) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= word;
          ptr       <= ptr + ADDR_W'(1);
          count     <= count + (ADDR_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: encoding table, back-to-back writes, illegal class, full stop,
// reset abort and restart, against hand-computed words and addresses.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic        in_valid, in_last;
  logic [2:0]  in_class;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [7:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [8:0]  count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) u_full (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2), .count(count2), .err(err2)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        last;
    logic [31:0] exp_word;
    logic [7:0]  exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one bundle for exactly one rising edge, then drop in_valid.
  task automatic send(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                      input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = funct; in_imm = imm; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start(input logic which);
    @(negedge clk);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{CLS_R,    5'd1, 5'd2, 5'd3, 6'b100000, 16'h0000, 1'b0, 32'h00221820, 8'd0};
    tbl[1] = '{CLS_LW,   5'd1, 5'd2, 5'd0, 6'd0,      16'h0004, 1'b0, 32'h8C220004, 8'd1};
    tbl[2] = '{CLS_SW,   5'd1, 5'd2, 5'd0, 6'd0,      16'h0008, 1'b0, 32'hAC220008, 8'd2};
    tbl[3] = '{CLS_BEQ,  5'd1, 5'd2, 5'd0, 6'd0,      16'hFFFF, 1'b0, 32'h1022FFFF, 8'd3};
    tbl[4] = '{CLS_ADDI, 5'd0, 5'd5, 5'd0, 6'd0,      16'h0007, 1'b1, 32'h20050007, 8'd4};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_class = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy_done", {busy, done, err}, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;

    // Encoding table
    pulse_start(1'b0);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].cls, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].funct, tbl[i].imm, tbl[i].last);
      chk($sformatf("enc%0d_we", i), mem_we, 1);
      chk($sformatf("enc%0d_addr", i), mem_addr, tbl[i].exp_addr);
      chk($sformatf("enc%0d_word", i), mem_wdata, tbl[i].exp_word);
    end
    chk("enc_done", done, 1);
    chk("enc_in_ready", in_ready, 0);
    chk("enc_count", count, 5);
    chk("enc_err", err, 0);
    @(posedge clk); #1;
    chk("enc_we_pulse", mem_we, 0);
    chk("enc_addr_hold", mem_addr, 4);
    chk("enc_word_hold", mem_wdata, 32'h20050007);

    // Restart from DONE, then illegal class between legal bundles
    pulse_start(1'b0);
    chk("rs1_done", done, 0);
    chk("rs1_count", count, 0);
    chk("rs1_busy", busy, 1);
    send(CLS_R, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0, 1'b0);
    chk("ill_first_addr", mem_addr, 0);
    send(3'd6, 5'd1, 5'd2, 5'd3, 6'd0, 16'h1234, 1'b0);
    chk("ill_no_we", mem_we, 0);
    chk("ill_err", err, 1);
    chk("ill_count", count, 1);
    send(CLS_LW, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 1'b0);
    chk("ill_next_we", mem_we, 1);
    chk("ill_next_addr", mem_addr, 1);
    chk("ill_next_count", count, 2);
    for (int g = 0; g < 2; g++) begin
      @(posedge clk); #1;
      chk($sformatf("gap%0d_no_we", g), mem_we, 0);
    end

    // Five consecutive transfers -> five consecutive writes
    @(negedge clk);
    in_valid = 1'b1; in_class = CLS_ADDI; in_rs = 5'd0; in_rt = 5'd0; in_imm = 16'd0; in_last = 1'b0;
    chk("b2b_pre_we", mem_we, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_we", i), mem_we, 1);
      chk($sformatf("b2b%0d_addr", i), mem_addr, 2 + i);
      chk($sformatf("b2b%0d_word", i), mem_wdata, 32'h20000000 | (i << 21) | (i << 16) | i);
      in_rs = 5'(i + 1); in_rt = 5'(i + 1); in_imm = 16'(i + 1); in_last = (i + 1 == 4);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_done", done, 1);
    chk("b2b_count", count, 7);
    chk("b2b_err_sticky", err, 1);
    @(posedge clk); #1;
    chk("b2b_we_end", mem_we, 0);

    // Restart clears err; then reset mid-load
    pulse_start(1'b0);
    chk("rs2_err", err, 0);
    chk("rs2_count", count, 0);
    send(CLS_SW, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 1'b0);
    chk("abort_pre_we", mem_we, 1);
    rst = 1'b1; #1;
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    chk("abort_addr", mem_addr, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_we", mem_we, 0);
    pulse_start(1'b0);
    // rd/funct are junk for LW and must not leak into the word
    send(CLS_LW, 5'd1, 5'd2, 5'd31, 6'h3F, 16'h0004, 1'b1);
    chk("reload_addr", mem_addr, 0);
    chk("reload_word", mem_wdata, 32'h8C220004);
    chk("reload_count", count, 1);

    // Full stop on the DEPTH=4 instance
    pulse_start(1'b1);
    chk("full_busy", busy2, 1);
    for (int i = 0; i < 6; i++) begin
      send(CLS_SW, 5'd0, 5'd1, 5'd0, 6'd0, 16'(i), 1'b0);
      chk($sformatf("full%0d_we", i), mem_we2, (i < 4) ? 1 : 0);
      if (i < 4) chk($sformatf("full%0d_addr", i), mem_addr2, i);
    end
    chk("full_done", done2, 1);
    chk("full_in_ready", in_ready2, 0);
    chk("full_count", count2, 4);
    chk("full_addr_hold", mem_addr2, 3);
    chk("full_word_hold", mem_wdata2, 32'hAC010003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
